// File: rtl/sqrt_fsm.sv
// Multi-cycle binary32 square root: restoring digit-by-digit loop, one root bit per clock.
// Truncated result, zero/subnormal flushed, negative and NaN operands flagged on err.
module sqrt_fsm (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] x,
  input  logic        r_i,
  output logic [31:0] res,
  output logic        err,
  output logic        r_o,
  output logic        busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CHECK = 2'd1;
  localparam logic [1:0] ITER  = 2'd2;
  localparam logic [1:0] PACK  = 2'd3;

  logic [1:0]  state;
  logic [31:0] x_q;
  logic [47:0] rad;
  logic [23:0] root;
  logic [25:0] rem;
  logic [4:0]  cnt;
  logic [7:0]  exp_q;
  logic [31:0] res_q;
  logic        err_q;

  logic        s_in;
  logic [7:0]  e_in;
  logic [22:0] m_in;
  logic [7:0]  exp_calc;
  logic [25:0] rem_sh;
  logic [25:0] sub;
  logic        ge;
  logic [25:0] rem_nx;
  logic [23:0] root_nx;

  always_comb begin
    s_in     = x_q[31];
    e_in     = x_q[30:23];
    m_in     = x_q[22:0];
    // (e + 126 + e[0]) >> 1 rewritten without the always-zero LSB
    exp_calc = {1'b0, e_in[7:1]} + 8'd63 + {7'd0, e_in[0]};
    rem_sh   = {rem[23:0], rad[47:46]};
    sub      = {root, 2'b01};
    // full-width compare; the modular 26-bit difference is exact whenever ge holds
    ge       = ({rem, rad[47:46]} >= {2'b00, sub});
    if (ge) begin
      rem_nx  = rem_sh - sub;
      root_nx = {root[22:0], 1'b1};
    end else begin
      rem_nx  = rem_sh;
      root_nx = {root[22:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      x_q   <= '0;
      rad   <= '0;
      root  <= '0;
      rem   <= '0;
      cnt   <= '0;
      exp_q <= '0;
      res_q <= '0;
      err_q <= 1'b0;
      res   <= '0;
      err   <= 1'b0;
      r_o   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      r_o <= 1'b0;
      case (state)
        IDLE: begin
          if (r_i) begin
            x_q   <= x;
            busy  <= 1'b1;
            state <= CHECK;
          end
        end
        CHECK: begin
          if (e_in == 8'd0) begin
            res_q <= {s_in, 31'b0};
            err_q <= 1'b0;
            state <= PACK;
          end else if (s_in) begin
            res_q <= '0;
            err_q <= 1'b1;
            state <= PACK;
          end else if (e_in == 8'hFF) begin
            res_q <= (m_in != 23'd0) ? 32'h0000_0000 : 32'h7F80_0000;
            err_q <= (m_in != 23'd0);
            state <= PACK;
          end else begin
            rad   <= e_in[0] ? {2'b01, m_in, 23'b0} : {1'b1, m_in, 24'b0};
            exp_q <= exp_calc;
            root  <= '0;
            rem   <= '0;
            cnt   <= '0;
            state <= ITER;
          end
        end
        ITER: begin
          rad  <= {rad[45:0], 2'b00};
          root <= root_nx;
          rem  <= rem_nx;
          cnt  <= cnt + 5'd1;
          if (cnt == 5'd23) begin
            res_q <= {1'b0, exp_q, root_nx[22:0]};
            err_q <= 1'b0;
            state <= PACK;
          end
        end
        PACK: begin
          res   <= res_q;
          err   <= err_q;
          r_o   <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_fsm.sv
// Directed and random checks for sqrt_fsm against a bit-by-bit integer square-root model,
// with expected results queued at request time and popped on each r_o pulse.
module tb_sqrt_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] x;
  logic        r_i;
  logic [31:0] res;
  logic        err;
  logic        r_o;
  logic        busy;

  sqrt_fsm dut (
    .clk  (clk),
    .rst  (rst),
    .x    (x),
    .r_i  (r_i),
    .res  (res),
    .err  (err),
    .r_o  (r_o),
    .busy (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] last_res = '0;
  logic        last_err = 1'b0;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  function automatic bit is_special(input logic [31:0] v);
    return (v[30:23] == 8'd0) || v[31] || (v[30:23] == 8'hFF);
  endfunction

  // Reference: value = 1.m * 2^k; root found by greedy bit setting with squaring.
  function automatic exp_t model(input logic [31:0] v);
    exp_t            r;
    logic [7:0]      e;
    logic [22:0]     m;
    int              k;
    longint unsigned n, t, q;
    e = v[30:23];
    m = v[22:0];
    r.res = '0;
    r.err = 1'b0;
    if (e == 8'd0) begin
      r.res = {v[31], 31'b0};
    end else if (v[31]) begin
      r.err = 1'b1;
    end else if (e == 8'hFF) begin
      if (m != 23'd0) r.err = 1'b1;
      else            r.res = 32'h7F80_0000;
    end else begin
      k = int'(e) - 127;
      n = 64'({1'b1, m});
      n = ((k & 1) != 0) ? (n << 24) : (n << 23);
      q = 0;
      for (int b = 23; b >= 0; b--) begin
        t = q | (64'd1 << b);
        if (t * t <= n) q = t;
      end
      r.res = {1'b0, 8'(127 + (k >>> 1)), q[22:0]};
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] sp [5];
    sp[0] = 32'h8000_0000; sp[1] = 32'h0000_0001; sp[2] = 32'h7F80_0000;
    sp[3] = 32'hC080_0000; sp[4] = 32'h7FC0_0000;
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
    return {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
  endfunction

  task automatic run_one(input logic [31:0] xv, input logic [31:0] er, input logic ee,
                         input int lat, input string tag);
    exp_t e;
    exp_t got;
    int   cyc;
    bit   seen;
    e.res = er;
    e.err = ee;
    sb.push_back(e);
    x   = xv;
    r_i = 1'b1;
    @(posedge clk); #1;
    r_i = 1'b0;
    x   = $urandom;
    chk1({tag, "_busy_start"}, busy, 1'b1);
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (r_o) seen = 1;
    end
    chk32({tag, "_latency"}, 32'(cyc), 32'(lat));
    got = sb.pop_front();
    if (seen) begin
      chk32({tag, "_res"}, res, got.res);
      chk1({tag, "_err"}, err, got.err);
      chk1({tag, "_busy_done"}, busy, 1'b0);
    end
    last_res = got.res;
    last_err = got.err;
    @(posedge clk); #1;
    chk1({tag, "_pulse_width"}, r_o, 1'b0);
    chk32({tag, "_res_hold"}, res, got.res);
  endtask

  initial begin
    exp_t        m;
    exp_t        got;
    logic [31:0] xd;
    bit          active;
    bit          exp_pulse;
    int          pulse_in;
    int          n_pulse;
    int          n_busy;

    rst = 1'b1;
    r_i = 1'b0;
    x   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk32("reset_res", res, 32'h0);
    chk1("reset_err", err, 1'b0);
    chk1("reset_r_o", r_o, 1'b0);
    chk1("reset_busy", busy, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_one(32'h4080_0000, 32'h4000_0000, 1'b0, 26, "sqrt4");
    run_one(32'h4110_0000, 32'h4040_0000, 1'b0, 26, "sqrt9");
    run_one(32'h3E80_0000, 32'h3F00_0000, 1'b0, 26, "sqrt0p25");
    run_one(32'h4000_0000, 32'h3FB5_04F3, 1'b0, 26, "sqrt2");
    run_one(32'h4040_0000, 32'h3FDD_B3D7, 1'b0, 26, "sqrt3");
    run_one(32'h8000_0000, 32'h8000_0000, 1'b0, 2, "neg_zero");
    run_one(32'h0000_0001, 32'h0000_0000, 1'b0, 2, "subnormal");
    run_one(32'h7F80_0000, 32'h7F80_0000, 1'b0, 2, "pos_inf");
    run_one(32'hC080_0000, 32'h0000_0000, 1'b1, 2, "neg_four");
    run_one(32'h7FC0_0000, 32'h0000_0000, 1'b1, 2, "nan");
    run_one(32'h7F7F_FFFF, 32'h5F7F_FFFF, 1'b0, 26, "max_normal");
    run_one(32'h0080_0000, 32'h2000_0000, 1'b0, 26, "min_normal");

    // r_i held high, x changing every cycle; bench tracks accept edges itself
    active   = 0;
    pulse_in = 0;
    n_pulse  = 0;
    for (int c = 0; c < 150; c++) begin
      r_i = (c < 115);
      x   = rand_op();
      xd  = x;
      @(posedge clk);
      exp_pulse = 0;
      if (active) begin
        pulse_in--;
        if (pulse_in == 0) begin
          exp_pulse = 1;
          active    = 0;
        end
      end else if (r_i) begin
        sb.push_back(model(xd));
        pulse_in = is_special(xd) ? 2 : 26;
        active   = 1;
      end
      #1;
      chk1("b2b_r_o", r_o, exp_pulse);
      chk1("b2b_busy", busy, active);
      if (exp_pulse && sb.size() > 0) begin
        got = sb.pop_front();
        n_pulse++;
        chk32("b2b_res", res, got.res);
        chk1("b2b_err", err, got.err);
        last_res = got.res;
        last_err = got.err;
      end else begin
        chk32("b2b_res_hold", res, last_res);
        chk1("b2b_err_hold", err, last_err);
      end
    end
    r_i = 1'b0;
    chk1("b2b_drained", (n_pulse >= 4) && (sb.size() == 0), 1'b1);

    // Reset during the 10th ITER edge of sqrt(4)
    x   = 32'h4080_0000;
    r_i = 1'b1;
    @(posedge clk); #1;
    r_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk32("midrst_res", res, 32'h0);
    chk1("midrst_err", err, 1'b0);
    chk1("midrst_busy", busy, 1'b0);
    n_pulse = 0;
    n_busy  = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (r_o)  n_pulse++;
      if (busy) n_busy++;
    end
    chk32("midrst_no_pulse", 32'(n_pulse), 32'd0);
    chk32("midrst_no_busy", 32'(n_busy), 32'd0);

    // Reset and request on the same edge: request dropped
    rst = 1'b1;
    r_i = 1'b1;
    x   = 32'h4080_0000;
    @(posedge clk); #1;
    rst = 1'b0;
    r_i = 1'b0;
    chk1("rst_vs_req_busy", busy, 1'b0);
    n_pulse = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (r_o) n_pulse++;
    end
    chk32("rst_vs_req_no_pulse", 32'(n_pulse), 32'd0);

    run_one(32'h4110_0000, 32'h4040_0000, 1'b0, 26, "after_rst_sqrt9");

    for (int i = 0; i < 200; i++) begin
      xd = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
      m  = model(xd);
      run_one(xd, m.res, m.err, 26, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
